// File: rtl/sm3_sched_if.sv
// sm3_sched_if: load/advance handshake and expanded-word stream for the SM3 scheduler; round_oh exists only with SM3_SCHED_ONEHOT_EN.
interface sm3_sched_if #(parameter int ROUNDS = 64);
  logic         load;
  logic [511:0] block;
  logic         advance;
  logic [31:0]  w_j;
  logic [31:0]  w1_j;
  logic [6:0]   round;
  logic         valid;
  logic         busy;
  logic         done;
`ifdef SM3_SCHED_ONEHOT_EN
  logic [ROUNDS-1:0] round_oh;
  modport master (output load, block, advance, input w_j, w1_j, round, valid, busy, done, round_oh);
  modport slave (input load, block, advance, output w_j, w1_j, round, valid, busy, done, round_oh);
`else
  modport master (output load, block, advance, input w_j, w1_j, round, valid, busy, done);
  modport slave (input load, block, advance, output w_j, w1_j, round, valid, busy, done);
`endif
endinterface

// File: rtl/sm3_msg_sched.sv
// sm3_msg_sched: SM3 message expansion over a 16-word sliding window, one round per accepted advance.
// Define SM3_SCHED_ONEHOT_EN to add the registered one-hot round output round_oh.
module sm3_msg_sched #(
  parameter int ROUNDS = 64
) (
  input logic       clk_i,
  input logic       rst_i,
  sm3_sched_if.slave bus
);
  if (ROUNDS < 1 || ROUNDS > 128) begin : g_bad_rounds
    $error("sm3_msg_sched: ROUNDS must be within 1..128");
  end
  typedef enum logic {IDLE, RUN} state_e;
  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [6:0]  round_q, round_d;
  logic        done_q, done_d;
  logic        adv, last;
  logic [31:0] w_new;
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction
  assign adv   = bus.advance && state_q == RUN;
  assign last  = round_q == 7'(ROUNDS - 1);
  // win[0..15] holds W_j..W_{j+15}, so the new tail word is W_{j+16}
  assign w_new = p1(win_q[0] ^ win_q[7] ^ rotl(win_q[13], 15)) ^ rotl(win_q[3], 7) ^ win_q[10];
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    round_d = round_q;
    done_d  = 1'b0;
    if (bus.load) begin
      for (int i = 0; i < 16; i++) win_d[i] = bus.block[511 - 32*i -: 32];
      round_d = '0;
      state_d = RUN;
    end else if (adv) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = w_new;
      round_d   = last ? 7'd0 : round_q + 7'd1;
      state_d   = last ? IDLE : RUN;
      done_d    = last;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      win_q   <= '{default: '0};
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end
  assign bus.w_j   = win_q[0];
  assign bus.w1_j  = win_q[0] ^ win_q[4];
  assign bus.round = round_q;
  assign bus.valid = state_q == RUN;
  assign bus.busy  = state_q == RUN;
  assign bus.done  = done_q;
`ifdef SM3_SCHED_ONEHOT_EN
  logic [ROUNDS-1:0] oh_q, oh_d;
  assign oh_d = bus.load ? ROUNDS'(1) : adv ? (last ? '0 : oh_q << 1) : oh_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) oh_q <= '0;
    else oh_q <= oh_d;
  end
  assign bus.round_oh = oh_q;
`endif
endmodule

// File: tb/tb_sm3_msg_sched.sv
// tb_sm3_msg_sched: scoreboard bench; expected rounds are expanded from the block when it is loaded.
module tb_sm3_msg_sched;
`ifdef SM3_SCHED_ONEHOT_EN
  localparam int R = 17;
`else
  localparam int R = 64;
`endif
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  typedef struct packed {
    logic [6:0]  r;
    logic [31:0] w;
    logic [31:0] w1;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  logic [31:0] w_last;
  int n_cmp = 0;
  int n_bad = 0;
  sm3_sched_if #(.ROUNDS(R)) bus ();
  sm3_msg_sched #(.ROUNDS(R)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push_block(input logic [511:0] b);
    logic [31:0] wx [R+20];
    for (int j = 0; j < 16; j++) wx[j] = b[511 - 32*j -: 32];
    for (int j = 16; j < R + 4; j++)
      wx[j] = p1(wx[j-16] ^ wx[j-9] ^ rl(wx[j-3], 15)) ^ rl(wx[j-13], 7) ^ wx[j-6];
    sb.delete();
    for (int j = 0; j < R; j++) sb.push_back('{r: 7'(j), w: wx[j], w1: wx[j] ^ wx[j+4]});
    w_last = wx[R];
    bus.load  = 1'b1;
    bus.block = b;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    n_cmp++;
    if ({bus.w_j, bus.w1_j, bus.round, bus.valid, bus.busy, bus.done} !== '0) begin
      n_bad++;
      $display("FAIL reset_held got %h want 0", {bus.w_j, bus.w1_j, bus.round, bus.valid, bus.busy, bus.done});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      n_cmp++;
      if ({bus.w_j, bus.w1_j, bus.round, bus.valid, bus.busy, bus.done} !== '0) begin
        n_bad++;
        $display("FAIL reset_idle%0d got %h want 0", i, {bus.w_j, bus.w1_j, bus.round, bus.valid, bus.busy, bus.done});
      end
`ifdef SM3_SCHED_ONEHOT_EN
      n_cmp++;
      if (bus.round_oh !== '0) begin n_bad++; $display("FAIL reset_oh got %h want 0", bus.round_oh); end
`endif
      bus.advance = 1'b1;
    end
    bus.advance = 1'b0;
  endtask
  task automatic test_abc;
    push_block(ABC);
    step;
    bus.load = 1'b0;
    n_cmp++;
    if ({bus.valid, bus.busy, bus.done, bus.round, bus.w_j, bus.w1_j} !== {3'b110, 7'd0, 32'h61626380, 32'h61626380}) begin
      n_bad++;
      $display("FAIL abc_first got r=%0d w=%h w1=%h v=%b", bus.round, bus.w_j, bus.w1_j, bus.valid);
    end
    bus.advance = 1'b1;
    for (int i = 0; i < R; i++) begin
      if (i == 12) begin
        n_cmp++;
        if ({bus.w_j, bus.w1_j} !== {32'h0, 32'h9092E200}) begin
          n_bad++;
          $display("FAIL abc_r12 got w=%h w1=%h want 0 9092e200", bus.w_j, bus.w1_j);
        end
      end
      if (i == 16) begin
        n_cmp++;
        if (bus.w_j !== 32'h9092E200) begin n_bad++; $display("FAIL abc_r16 got %h want 9092e200", bus.w_j); end
      end
      n_cmp++;
      if (sb.size() == 0 || {bus.valid, bus.round, bus.w_j, bus.w1_j} !== {1'b1, sb[0]}) begin
        n_bad++;
        $display("FAIL abc_stream j=%0d got %h want %h", i, {bus.valid, bus.round, bus.w_j, bus.w1_j}, {1'b1, sb[0]});
      end
`ifdef SM3_SCHED_ONEHOT_EN
      n_cmp++;
      if (bus.round_oh !== (R'(1) << i)) begin n_bad++; $display("FAIL abc_oh j=%0d got %h want %h", i, bus.round_oh, R'(1) << i); end
`endif
      if (sb.size() != 0) void'(sb.pop_front());
      step;
    end
    n_cmp++;
    if ({bus.valid, bus.busy, bus.done, bus.round, bus.w_j} !== {3'b001, 7'd0, w_last}) begin
      n_bad++;
      $display("FAIL abc_done got v=%b d=%b r=%0d w=%h want done, w=%h", bus.valid, bus.done, bus.round, bus.w_j, w_last);
    end
`ifdef SM3_SCHED_ONEHOT_EN
    n_cmp++;
    if (bus.round_oh !== '0) begin n_bad++; $display("FAIL abc_oh_done got %h want 0", bus.round_oh); end
`endif
    for (int i = 0; i < 2; i++) begin
      step;
      n_cmp++;
      if ({bus.valid, bus.done, bus.round, bus.w_j} !== {2'b00, 7'd0, w_last}) begin
        n_bad++;
        $display("FAIL abc_idle%0d got v=%b d=%b r=%0d w=%h want idle w=%h", i, bus.valid, bus.done, bus.round, bus.w_j, w_last);
      end
    end
    bus.advance = 1'b0;
  endtask
  task automatic test_stall;
    push_block(ABC);
    step;
    bus.load = 1'b0;
    bus.advance = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (sb.size() != 0) void'(sb.pop_front());
      step;
    end
    bus.advance = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (sb.size() == 0 || {bus.valid, bus.round, bus.w_j, bus.w1_j} !== {1'b1, sb[0]}) begin
        n_bad++;
        $display("FAIL stall_hold%0d got %h want %h", i, {bus.valid, bus.round, bus.w_j, bus.w1_j}, {1'b1, sb[0]});
      end
      if (i < 5) step;
    end
    bus.advance = 1'b1;
    for (int i = 7; i < R; i++) begin
      n_cmp++;
      if (sb.size() == 0 || {bus.valid, bus.round, bus.w_j, bus.w1_j} !== {1'b1, sb[0]}) begin
        n_bad++;
        $display("FAIL stall_resume j=%0d got %h want %h", i, {bus.valid, bus.round, bus.w_j, bus.w1_j}, {1'b1, sb[0]});
      end
      if (sb.size() != 0) void'(sb.pop_front());
      step;
    end
    n_cmp++;
    if ({bus.valid, bus.done} !== 2'b01) begin n_bad++; $display("FAIL stall_done got v=%b d=%b want 0 1", bus.valid, bus.done); end
    bus.advance = 1'b0;
    step;
  endtask
  task automatic test_abort;
    logic [511:0] b2;
    for (int j = 0; j < 16; j++) b2[32*j +: 32] = $urandom();
    push_block(ABC);
    step;
    bus.load = 1'b0;
    bus.advance = 1'b1;
    repeat (R * 15 / 32) step;
    push_block(b2);
    step;
    bus.load = 1'b0;
    n_cmp++;
    if ({bus.valid, bus.done, bus.round, bus.w_j} !== {2'b10, 7'd0, b2[511:480]}) begin
      n_bad++;
      $display("FAIL abort_load got v=%b d=%b r=%0d w=%h want r=0 w=%h", bus.valid, bus.done, bus.round, bus.w_j, b2[511:480]);
    end
    for (int i = 0; i < R * 5 / 8; i++) begin
      n_cmp++;
      if (sb.size() == 0 || {bus.valid, bus.done, bus.round, bus.w_j, bus.w1_j} !== {2'b10, sb[0]}) begin
        n_bad++;
        $display("FAIL abort_stream j=%0d got %h want %h", i, {bus.valid, bus.done, bus.round, bus.w_j, bus.w1_j}, {2'b10, sb[0]});
      end
      if (sb.size() != 0) void'(sb.pop_front());
      step;
    end
    rst = 1'b1;
    bus.advance = 1'b0;
    step;
    n_cmp++;
    if ({bus.w_j, bus.w1_j, bus.round, bus.valid, bus.busy, bus.done} !== '0) begin
      n_bad++;
      $display("FAIL abort_reset got %h want 0", {bus.w_j, bus.w1_j, bus.round, bus.valid, bus.busy, bus.done});
    end
    rst = 1'b0;
    step;
  endtask
  task automatic test_back_to_back;
    logic [511:0] b3;
    for (int j = 0; j < 16; j++) b3[32*j +: 32] = $urandom();
    push_block(ABC);
    step;
    bus.load = 1'b0;
    bus.advance = 1'b1;
    repeat (R - 1) step;
    n_cmp++;
    if ({bus.valid, bus.round} !== {1'b1, 7'(R - 1)}) begin
      n_bad++;
      $display("FAIL b2b_final got v=%b r=%0d want 1 %0d", bus.valid, bus.round, R - 1);
    end
    push_block(b3);
    step;
    bus.load = 1'b0;
    for (int i = 0; i < R; i++) begin
      n_cmp++;
      if (sb.size() == 0 || {bus.valid, bus.done, bus.round, bus.w_j, bus.w1_j} !== {2'b10, sb[0]}) begin
        n_bad++;
        $display("FAIL b2b_stream j=%0d got %h want %h", i, {bus.valid, bus.done, bus.round, bus.w_j, bus.w1_j}, {2'b10, sb[0]});
      end
      if (sb.size() != 0) void'(sb.pop_front());
      step;
    end
    bus.advance = 1'b0;
    n_cmp++;
    if ({bus.valid, bus.done, bus.w_j} !== {2'b01, w_last}) begin
      n_bad++;
      $display("FAIL b2b_done got v=%b d=%b w=%h want 0 1 %h", bus.valid, bus.done, bus.w_j, w_last);
    end
    step;
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b_pulse got %b want 0", bus.done); end
  endtask
  initial begin
    bus.load    = 1'b0;
    bus.advance = 1'b0;
    bus.block   = '0;
    test_reset;
    test_abc;
    test_stall;
    test_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
